// File: rtl/reaction_timer_multi.sv
// Multi-player reaction timer: random wait, stimulus light, per-player ms capture, winner pick.
// Optional best-time register and best_o port are enabled by defining REACTION_BEST_TIME_EN.
module reaction_timer_multi #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int N_PLAYERS    = 2,
  parameter int MIN_DELAY_MS = 2000,
  parameter int MAX_DELAY_MS = 15000,
  parameter int TIMEOUT_MS   = 1000
) (
  input  logic                      CLK100MHZ,
  input  logic                      CPU_RESETN,
  input  logic                      start_i,
  input  logic                      clear_i,
  input  logic [N_PLAYERS-1:0]      btn_i,
  output logic                      stim_o,
  output logic [1:0]                state_o,
  output logic [14*N_PLAYERS-1:0]   time_o,
  output logic [N_PLAYERS-1:0]      hit_o,
  output logic [N_PLAYERS-1:0]      foul_o,
  output logic [1:0]                winner_o,
  output logic                      winner_valid_o,
  output logic                      done_o
`ifdef REACTION_BEST_TIME_EN
  ,
  output logic [13:0]               best_o
`endif
);

  localparam int DIV    = CLK_HZ / 1000;
  localparam int PS_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int MS_MAX = (MAX_DELAY_MS > TIMEOUT_MS) ? MAX_DELAY_MS : TIMEOUT_MS;
  localparam int MS_RAW = $clog2(MS_MAX + 1);
  localparam int MS_W   = (MS_RAW < 14) ? 14 : MS_RAW;
  localparam logic [31:0] DELAY_RANGE = 32'(MAX_DELAY_MS - MIN_DELAY_MS + 1);
  localparam logic [31:0] DELAY_MIN   = 32'(MIN_DELAY_MS);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ARMED = 2'd2, DONE = 2'd3} state_t;

  state_t                      state, state_next;
  logic                        start_q;
  logic [N_PLAYERS-1:0]        btn_q;
  logic                        start_edge;
  logic [N_PLAYERS-1:0]        btn_edge;
  logic [15:0]                 lfsr;
  logic [PS_W-1:0]             ps, ps_next;
  logic                        tick;
  logic [MS_W-1:0]             ms, ms_next, delay, delay_next;
  logic [N_PLAYERS-1:0][13:0]  times, times_next;
  logic [N_PLAYERS-1:0]        hit, hit_next, foul, foul_next, new_hit;
  logic [1:0]                  winner, winner_next, win_idx;
  logic                        wvalid, wvalid_next, done_r, done_next, stim_r, stim_next;
  logic                        finish, found;
  logic [13:0]                 win_time;
`ifdef REACTION_BEST_TIME_EN
  logic [13:0]                 best, best_next;
`endif

  assign start_edge = start_i & ~start_q;
  assign btn_edge   = btn_i & ~btn_q;
  assign tick       = (ps == PS_W'(DIV - 1));

  always_comb begin
    state_next  = state;
    delay_next  = delay;
    times_next  = times;
    hit_next    = hit;
    foul_next   = foul;
    winner_next = winner;
    wvalid_next = wvalid;
    done_next   = 1'b0;
    new_hit     = '0;
    finish      = 1'b0;
    found       = 1'b0;
    win_idx     = '0;
    win_time    = '0;
`ifdef REACTION_BEST_TIME_EN
    best_next   = best;
`endif
    if (state == WAIT || state == ARMED) begin
      ps_next = tick ? '0 : ps + PS_W'(1);
      ms_next = tick ? ms + MS_W'(1) : ms;
    end else begin
      ps_next = '0;
      ms_next = ms;
    end

    if (clear_i) begin
      state_next  = IDLE;
      times_next  = '0;
      hit_next    = '0;
      foul_next   = '0;
      winner_next = '0;
      wvalid_next = 1'b0;
      ps_next     = '0;
      ms_next     = '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_edge) begin
            state_next  = WAIT;
            delay_next  = MS_W'(DELAY_MIN + ({16'd0, lfsr} % DELAY_RANGE));
            times_next  = '0;
            hit_next    = '0;
            foul_next   = '0;
            wvalid_next = 1'b0;
            ps_next     = '0;
            ms_next     = '0;
          end
        end
        WAIT: begin
          foul_next = foul | btn_edge;
          if (&foul_next) begin
            finish = 1'b1;
          end else if (ms == delay) begin
            state_next = ARMED;
            ps_next    = '0;
            ms_next    = '0;
          end
        end
        ARMED: begin
          // Timeout wins over any edge arriving on the same cycle; the window is ms < TIMEOUT_MS.
          if (ms == MS_W'(TIMEOUT_MS)) begin
            for (int k = 0; k < N_PLAYERS; k++)
              if (!hit[k]) times_next[k] = 14'(TIMEOUT_MS);
            finish = 1'b1;
          end else begin
            new_hit = btn_edge & ~foul & ~hit;
            for (int k = 0; k < N_PLAYERS; k++)
              if (new_hit[k]) times_next[k] = ms[13:0];
            hit_next = hit | new_hit;
            if (&(hit_next | foul)) finish = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    for (int k = 0; k < N_PLAYERS; k++) begin
      if (hit_next[k] && (!found || times_next[k] < win_time)) begin
        found    = 1'b1;
        win_idx  = 2'(k);
        win_time = times_next[k];
      end
    end

    if (finish) begin
      state_next  = DONE;
      done_next   = 1'b1;
      wvalid_next = found;
      winner_next = win_idx;
`ifdef REACTION_BEST_TIME_EN
      if (found && win_time < best) best_next = win_time;
`endif
    end
    stim_next = (state_next == ARMED);
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state   <= IDLE;
      start_q <= 1'b0;
      btn_q   <= '0;
      lfsr    <= 16'hACE1;
      ps      <= '0;
      ms      <= '0;
      delay   <= '0;
      times   <= '0;
      hit     <= '0;
      foul    <= '0;
      winner  <= '0;
      wvalid  <= 1'b0;
      done_r  <= 1'b0;
      stim_r  <= 1'b0;
`ifdef REACTION_BEST_TIME_EN
      best    <= 14'd9999;
`endif
    end else begin
      state   <= state_next;
      start_q <= start_i;
      btn_q   <= btn_i;
      lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      ps      <= ps_next;
      ms      <= ms_next;
      delay   <= delay_next;
      times   <= times_next;
      hit     <= hit_next;
      foul    <= foul_next;
      winner  <= winner_next;
      wvalid  <= wvalid_next;
      done_r  <= done_next;
      stim_r  <= stim_next;
`ifdef REACTION_BEST_TIME_EN
      best    <= best_next;
`endif
    end
  end

  assign stim_o         = stim_r;
  assign state_o        = state;
  assign time_o         = times;
  assign hit_o          = hit;
  assign foul_o         = foul;
  assign winner_o       = winner;
  assign winner_valid_o = wvalid;
  assign done_o         = done_r;
`ifdef REACTION_BEST_TIME_EN
  assign best_o         = best;
`endif

endmodule

// File: doc/reaction_timer_multi.md
REACTION_TIMER_MULTI -- requirements
Module: reaction_timer_multi

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, input clock frequency; CLK_HZ/1000 SHALL be an integer of at least 1.
REQ-002 Parameter N_PLAYERS, default 2, number of player buttons, legal range 1..4.
REQ-003 Parameter MIN_DELAY_MS, default 2000, shortest random wait.
REQ-004 Parameter MAX_DELAY_MS, default 15000, longest random wait; it SHALL be at least MIN_DELAY_MS.
REQ-005 Parameter TIMEOUT_MS, default 1000, response window after the stimulus; it SHALL be at most 9999.
REQ-006 CLK100MHZ  in  1  sole clock; all logic on its rising edge.
REQ-007 CPU_RESETN  in  1  asynchronous, active-low reset.
REQ-008 start_i  in  1  start request; only its rising edge is used.
REQ-009 clear_i  in  1  synchronous clear (level).
REQ-010 btn_i  in  N_PLAYERS  player buttons, already debounced; only rising edges are used.
REQ-011 stim_o  out  1  stimulus light.
REQ-012 state_o  out  2  encoding 0 IDLE, 1 WAIT, 2 ARMED, 3 DONE.
REQ-013 time_o  out  14*N_PLAYERS  reaction time per player in ms; player k occupies bits [14k+13:14k].
REQ-014 hit_o  out  N_PLAYERS  player responded within the window.
REQ-015 foul_o  out  N_PLAYERS  player pressed before the stimulus.
REQ-016 winner_o  out  2  index of the fastest player.
REQ-017 winner_valid_o  out  1  winner_o is meaningful.
REQ-018 done_o  out  1  one-cycle pulse on entry to DONE.
REQ-019 best_o  out  14  best time in ms; present only when the configuration macro is defined.

Function
REQ-020 Edge detection SHALL use one registered copy of each of start_i and btn_i: edge = input & ~registered copy.
REQ-021 A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) SHALL step every cycle in every state.
REQ-022 IDLE or DONE + start edge -> WAIT. On that same edge:
  - latch delay_ms = MIN_DELAY_MS + (lfsr mod (MAX_DELAY_MS-MIN_DELAY_MS+1));
  - clear time_o, hit_o, foul_o, winner_valid_o;
  - reset the ms prescaler and the ms counter.
REQ-023 A start edge in WAIT or ARMED SHALL be ignored.
REQ-024 The ms tick SHALL assert for one cycle every CLK_HZ/1000 cycles, counted from the state entry.
REQ-025 WAIT, player button edge -> set foul_o[k] for that player.
REQ-026 WAIT, all players fouled -> DONE, with winner_valid_o=0.
REQ-027 WAIT, ms counter reaches delay_ms -> ARMED; stim_o=1 from the next cycle; the ms counter restarts from 0.
REQ-028 ARMED, button edge from a non-fouled player without a prior capture -> time_o[k] = current ms count and hit_o[k]=1.
REQ-029 Players whose edges arrive in the same cycle SHALL receive equal times.
REQ-030 A button held high from WAIT into ARMED SHALL NOT register as a hit.
REQ-031 ARMED -> DONE when every non-fouled player has hit, or when the ms counter reaches TIMEOUT_MS.
REQ-032 On timeout, each non-hit player SHALL get time_o[k]=TIMEOUT_MS and hit_o[k]=0.
REQ-033 stim_o SHALL be 1 only in ARMED.
REQ-034 On entry to DONE, winner_o SHALL be the hit player with the minimum time; a tie goes to the lowest index.
REQ-035 winner_valid_o SHALL be 1 iff at least one player hit.
REQ-036 In DONE, results SHALL hold until the next start edge or clear.
REQ-037 clear_i=1 -> IDLE next cycle from any state, clearing all results except best_o.
REQ-038 clear_i SHALL take priority over a start edge and over button edges in the same cycle.

Reset
REQ-039 CPU_RESETN=0 SHALL asynchronously force:
  - state to IDLE;
  - stim_o, done_o, winner_valid_o to 0;
  - time_o, hit_o, foul_o, winner_o to 0;
  - best_o to 14'd9999;
  - LFSR to 16'hACE1;
  - the prescaler, ms counter and edge registers to 0.
REQ-040 Reset asserted mid-round SHALL abort the round with no done_o pulse.

Configuration
REQ-041 Macro REACTION_BEST_TIME_EN defined: best_o register exists and is updated on DONE entry with a valid winner when the winner's time is below best_o; clear_i SHALL NOT alter it.
REQ-042 Macro REACTION_BEST_TIME_EN undefined: the best_o port and its register SHALL be absent; all other behaviour SHALL be unchanged.

Verification (CLK_HZ=1000, i.e. one cycle per ms; MIN=MAX=5; TIMEOUT=10; N=2)
REQ-043 Start edge -> stim_o rises 6 cycles later; press btn0 3 cycles after that and btn1 7 cycles after -> time0=3, time1=7, winner_o=0, winner_valid_o=1, done_o pulses once.
REQ-044 btn1 edge during WAIT -> foul_o=2'b10; btn0 hits at ms 4 -> DONE immediately with winner_o=0.
REQ-045 No presses -> DONE at ms 10; time_o=10 for both players, hit_o=0, winner_valid_o=0.
REQ-046 Both buttons rise in the same cycle at ms 2 -> both times=2, winner_o=0.
REQ-047 clear_i and a start edge in the same cycle during ARMED -> IDLE, outputs cleared; with the macro defined, best_o keeps its prior value.
REQ-048 Macro defined: successive rounds with winning times 7 then 3 then 5 -> best_o reads 9999, 7, 3, 3 respectively.
